// File: rtl/muldiv_sequencer.sv
// Launches one MULT/DIV on the shared units and commits HI/LO or raises divide-by-zero.
// Define MULDIV_TIMEOUT_EN to add a watchdog that aborts a WAIT lasting TIMEOUT_CYCLES.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int LAT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             kill,
  input  logic             mult_stop,
  input  logic             div_stop,
  input  logic             div_zero,
  output logic             mult_init,
  output logic             div_init,
  output logic             mux_high_sel,
  output logic             mux_low_sel,
  output logic             high_load,
  output logic             low_load,
  output logic             busy,
  output logic             done,
  output logic             div_zero_exc,
  output logic             timeout_exc,
  output logic [LAT_W-1:0] last_lat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_COMMIT,
    S_EXC
  } state_t;

  localparam logic [LAT_W-1:0] CNT_MAX = '1;
`ifdef MULDIV_TIMEOUT_EN
  localparam logic [LAT_W-1:0] TO_CNT = LAT_W'(TIMEOUT_CYCLES);
`endif

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [LAT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             tmo_q, tmo_d;
  logic             sel_stop;

  logic mi_q, mi_d, di_q, di_d;
  logic sel_q, sel_d, ld_q, ld_d;
  logic busy_q, busy_d, dz_q, dz_d;

  always_comb begin
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q
                                  : cnt_q + LAT_W'(1);
    sel_stop = op_q ? div_stop : mult_stop;
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    tmo_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          cnt_d   = '0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (kill) begin
          lat_d   = cnt_inc;
          state_d = S_IDLE;
        end else if (op_q && div_zero) begin
          state_d = S_EXC;
        end else if (sel_stop) begin
          state_d = S_COMMIT;
`ifdef MULDIV_TIMEOUT_EN
        end else if (cnt_inc == TO_CNT) begin
          lat_d   = cnt_inc;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
`endif
        end
      end
      S_COMMIT, S_EXC: begin
        lat_d   = cnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they leave flops cleanly.
  always_comb begin
    mi_d   = (state_d == S_LAUNCH) && !op_d;
    di_d   = (state_d == S_LAUNCH) && op_d;
    sel_d  = op_d;
    ld_d   = (state_d == S_COMMIT);
    busy_d = (state_d != S_IDLE);
    dz_d   = (state_d == S_EXC);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      lat_q   <= '0;
      tmo_q   <= 1'b0;
      mi_q    <= 1'b0;
      di_q    <= 1'b0;
      sel_q   <= 1'b0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      tmo_q   <= tmo_d;
      mi_q    <= mi_d;
      di_q    <= di_d;
      sel_q   <= sel_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
    end
  end

  assign mult_init    = mi_q;
  assign div_init     = di_q;
  assign mux_high_sel = sel_q;
  assign mux_low_sel  = sel_q;
  assign high_load    = ld_q;
  assign low_load     = ld_q;
  assign done         = ld_q;
  assign busy         = busy_q;
  assign div_zero_exc = dz_q;
  assign timeout_exc  = tmo_q;
  assign last_lat     = lat_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus queues expected
// commit/exception events, a negedge monitor pops and checks them.
module tb_muldiv_sequencer;

  localparam int LAT_W = 8;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic reset, start, op, kill;
  logic mult_stop, div_stop, div_zero;
  logic mult_init, div_init, mux_high_sel, mux_low_sel;
  logic high_load, low_load, busy, done;
  logic div_zero_exc, timeout_exc;
  logic [LAT_W-1:0] last_lat;

  muldiv_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .LAT_W(LAT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .kill(kill), .mult_stop(mult_stop), .div_stop(div_stop),
    .div_zero(div_zero), .mult_init(mult_init), .div_init(div_init),
    .mux_high_sel(mux_high_sel), .mux_low_sel(mux_low_sel),
    .high_load(high_load), .low_load(low_load), .busy(busy),
    .done(done), .div_zero_exc(div_zero_exc),
    .timeout_exc(timeout_exc), .last_lat(last_lat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int sel;
    int cyc;
    int lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   inits = 0;
  int   e0;
  bit   lat_pend = 0;
  int   lat_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic o, input logic hold);
    start = 1'b1;
    op    = o;
    tick(1);
    start = hold;
    e0    = cyc;
    @(negedge clk);
    chk("mult_init", int'(mult_init), int'(!o));
    chk("div_init", int'(div_init), int'(o));
    tick(1);
  endtask

  task automatic push(input int k, input int s, input int c, input int l);
    exp_t e;
    e.kind = k;
    e.sel  = s;
    e.cyc  = c;
    e.lat  = l;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (mult_init || div_init) inits++;
    if (lat_pend) begin
      chk("last_lat", int'(last_lat), lat_exp);
      lat_pend = 0;
    end
    if (high_load || low_load || done)
      chk("load_done", {29'd0, high_load, low_load, done}, 7);
    if (done || div_zero_exc || timeout_exc) begin
      k = done ? 0 : (div_zero_exc ? 1 : 2);
      if (q.size() == 0) begin
        chk("unexpected_event", k, -1);
      end else begin
        e = q.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_cyc", cyc, e.cyc);
        if (k == 0) begin
          chk("mux_high_sel", int'(mux_high_sel), e.sel);
          chk("mux_low_sel", int'(mux_low_sel), e.sel);
        end
        if (k == 2) begin
          chk("last_lat_tmo", int'(last_lat), e.lat);
        end else begin
          lat_pend = 1;
          lat_exp  = e.lat;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_outs"},
        {22'd0, mult_init, div_init, mux_high_sel, mux_low_sel,
         high_load, low_load, busy, done, div_zero_exc, timeout_exc},
        0);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; op = 1'b0; kill = 1'b0;
    mult_stop = 1'b0; div_stop = 1'b0; div_zero = 1'b0;
    tick(3);
    @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_lat", int'(last_lat), 0);
    reset = 1'b1;
    tick(1);

    // MULT, stop in WAIT cycle 32
    n = 32;
    launch(1'b0, 1'b0);
    push(0, 0, e0 + n + 1, 32);
    tick(n - 1);
    mult_stop = 1'b1;
    tick(1);
    mult_stop = 1'b0;
    tick(1);
    @(negedge clk);
    chk("mult_busy_after", int'(busy), 0);
    tick(1);

    // DIV with zero divisor, div_stop also high, WAIT cycle 3
    n = 3;
    launch(1'b1, 1'b0);
    push(1, 1, e0 + n + 1, 3);
    tick(n - 1);
    div_zero = 1'b1;
    div_stop = 1'b1;
    tick(1);
    div_zero = 1'b0;
    div_stop = 1'b0;
    tick(3);

    // DIV with start held high throughout WAIT
    n = 10;
    launch(1'b1, 1'b1);
    push(0, 1, e0 + n + 1, 10);
    tick(n - 1);
    div_stop = 1'b1;
    tick(1);
    div_stop = 1'b0;
    start = 1'b0;
    n = inits;
    tick(5);
    chk("no_relaunch", inits, n);

    // MULT killed in WAIT cycle 5
    launch(1'b0, 1'b0);
    tick(4);
    kill = 1'b1;
    tick(1);
    kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", int'(busy), 0);
    chk("kill_lat", int'(last_lat), 5);
    tick(1);

    // MULT where only the divider's stop fires
    launch(1'b0, 1'b0);
    tick(2);
    div_stop = 1'b1;
    tick(1);
    div_stop = 1'b0;
    tick(4);
    @(negedge clk);
    chk("wrong_stop_busy", int'(busy), 1);
    kill = 1'b1;
    tick(1);
    kill = 1'b0;
    tick(1);

    // reset in the middle of WAIT
    launch(1'b1, 1'b0);
    tick(3);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    chk("midreset_lat", int'(last_lat), 0);
    tick(1);

    n = 32;
    launch(1'b0, 1'b0);
    push(0, 0, e0 + n + 1, 32);
    tick(n - 1);
    mult_stop = 1'b1;
    tick(1);
    mult_stop = 1'b0;
    tick(1);
    @(negedge clk);
    chk("mult2_busy_after", int'(busy), 0);
    tick(1);

    // MULT with no stop at all
    launch(1'b0, 1'b0);
`ifdef MULDIV_TIMEOUT_EN
    push(2, 0, e0 + TMO + 1, TMO);
    tick(TMO + 3);
    @(negedge clk);
    chk("tmo_busy", int'(busy), 0);
`else
    tick(200);
    @(negedge clk);
    chk("hold_busy", int'(busy), 1);
    kill = 1'b1;
    tick(1);
    kill = 1'b0;
`endif
    tick(3);
    chk("pending_events", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
